// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: sequencer states,
// datapath mux selects, opcode constants and the opcode decode helpers.
package multi_cycle_control_unit_pkg;

  // Sequencer states, 5-bit encoding.
  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_EX_R    = 5'd2,
    S_EX_I    = 5'd3,
    S_EX_LUI  = 5'd4,
    S_EX_ADDR = 5'd5,
    S_MEM_RD  = 5'd6,
    S_MEM_WR  = 5'd7,
    S_WB_ALU  = 5'd8,
    S_WB_MEM  = 5'd9,
    S_EX_BR   = 5'd10,
    S_EX_JAL  = 5'd11,
    S_EX_JALR = 5'd12,
    S_ECALL   = 5'd13,
    S_HALT    = 5'd14,
    S_ILLEGAL = 5'd15
  } state_t;

  // RV32I major opcodes (IR[6:0]).
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_LUI            = 7'b0110111;
  localparam logic [6:0] OP_AUIPC          = 7'b0010111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  // PC source select.
  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  // Register file writeback source.
  localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
  localparam logic [1:0] WB_SEL_MDR    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;

  // ALU A operand.
  localparam logic [1:0] ALU_A_PC   = 2'd0;
  localparam logic [1:0] ALU_A_RS1  = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  // ALU B operand.
  localparam logic [1:0] ALU_B_RS2 = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;

  // ALU operation class.
  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd2;

  // Immediate format for the immediate generator. Zero means "no immediate"
  // so that the reset / fetch value never aliases a real format.
  localparam logic [2:0] IMM_SEL_NONE = 3'd0;
  localparam logic [2:0] IMM_SEL_I    = 3'd1;
  localparam logic [2:0] IMM_SEL_S    = 3'd2;
  localparam logic [2:0] IMM_SEL_B    = 3'd3;
  localparam logic [2:0] IMM_SEL_U    = 3'd4;
  localparam logic [2:0] IMM_SEL_J    = 3'd5;

  // State that follows S_ID for a given opcode.
  function automatic state_t decode_dispatch(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_ARITHMETIC:     nxt = S_EX_R;
      OP_ARITHMETIC_IMM: nxt = S_EX_I;
      OP_LOAD,
      OP_STORE:          nxt = S_EX_ADDR;
      OP_BRANCH:         nxt = S_EX_BR;
      OP_JAL:            nxt = S_EX_JAL;
      OP_JALR:           nxt = S_EX_JALR;
      OP_LUI:            nxt = S_EX_LUI;
      OP_AUIPC:          nxt = S_WB_ALU;
      OP_ECALL:          nxt = S_ECALL;
      default:           nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

  // Immediate format implied by the opcode; ECALL shares the I layout.
  function automatic logic [2:0] decode_imm_sel(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_ARITHMETIC_IMM,
      OP_LOAD,
      OP_JALR,
      OP_ECALL:          sel = IMM_SEL_I;
      OP_STORE:          sel = IMM_SEL_S;
      OP_BRANCH:         sel = IMM_SEL_B;
      OP_LUI,
      OP_AUIPC:          sel = IMM_SEL_U;
      OP_JAL:            sel = IMM_SEL_J;
      default:           sel = IMM_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_micro_sequencer.sv
// State register and next-state logic of the multi-cycle control unit.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IF      | fetch; wait for mem_ready, IR/MDR load in the ready cycle
// S_ID      | decode; ALUOut <- PC + imm, dispatch on opcode
// S_EX_R    | register-register ALU op
// S_EX_I    | register-immediate ALU op
// S_EX_LUI  | 0 + imm
// S_EX_ADDR | effective address rs1 + imm for load/store
// S_MEM_RD  | data read; wait for mem_ready
// S_MEM_WR  | data write; wait for mem_ready, PC <- PC+4 in ready cycle
// S_WB_ALU  | write ALUOut to rd, PC <- PC+4
// S_WB_MEM  | write MDR to rd, PC <- PC+4
// S_EX_BR   | compare, PC <- taken ? ALUOut : PC+4
// S_EX_JAL  | rd <- PC+4, PC <- ALUOut
// S_EX_JALR | rd <- PC+4, PC <- rs1 + imm
// S_ECALL   | halt if requested, else PC <- PC+4
// S_HALT    | terminal, halted
// S_ILLEGAL | terminal, unknown opcode
module multi_cycle_control_unit_micro_sequencer
  import multi_cycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       halt_req,
  output state_t     state
);

  state_t state_next;

  // State register; reset parks the sequencer in fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      S_IF:      if (mem_ready) state_next = S_ID;
      S_ID:      state_next = decode_dispatch(opcode);
      S_EX_R,
      S_EX_I,
      S_EX_LUI:  state_next = S_WB_ALU;
      S_EX_ADDR: state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) state_next = S_WB_MEM;
      S_MEM_WR:  if (mem_ready) state_next = S_IF;
      S_WB_ALU,
      S_WB_MEM,
      S_EX_BR,
      S_EX_JAL,
      S_EX_JALR: state_next = S_IF;
      S_ECALL:   state_next = halt_req ? S_HALT : S_IF;
      S_HALT:    state_next = S_HALT;
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control unit: sequencer plus datapath control decode.
// Outputs are gated by reset so an in-flight memory request drops at once.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       is_halted,
  output logic       illegal_inst
);

  state_t state;

  multi_cycle_control_unit_micro_sequencer u_seq (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .state     (state)
  );

  // Per-state datapath control decode; everything idles at 0.
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PC4;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_SEL_ALUOUT;
    alu_src_a    = ALU_A_PC;
    alu_src_b    = ALU_B_RS2;
    alu_op       = ALU_OP_ADD;
    imm_sel      = IMM_SEL_NONE;
    is_halted    = 1'b0;
    illegal_inst = 1'b0;

    if (!reset) begin
      if (state != S_IF) imm_sel = decode_imm_sel(opcode);

      case (state)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_ID: begin
          alu_src_a = ALU_A_PC;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_ADD;
        end
        S_EX_R: begin
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_RS2;
          alu_op    = ALU_OP_FUNCT;
        end
        S_EX_I: begin
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_FUNCT;
        end
        S_EX_LUI: begin
          alu_src_a = ALU_A_ZERO;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_ADD;
        end
        S_EX_ADDR: begin
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          pc_write  = mem_ready;
          pc_src    = PC_SRC_PC4;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_ALUOUT;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_PC4;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_MDR;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_PC4;
        end
        S_EX_BR: begin
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_RS2;
          alu_op    = ALU_OP_BRANCH;
          pc_write  = 1'b1;
          pc_src    = bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
        end
        S_EX_JAL: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_PC4;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_ALUOUT;
        end
        S_EX_JALR: begin
          // Target LSB is cleared in the datapath, not here.
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_ADD;
          reg_write = 1'b1;
          wb_sel    = WB_SEL_PC4;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_ALU;
        end
        S_ECALL: begin
          pc_write = !halt_req;
          pc_src   = PC_SRC_PC4;
        end
        S_HALT:    is_halted    = 1'b1;
        S_ILLEGAL: illegal_inst = 1'b1;
        default:   illegal_inst = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit. The stimulus process drives one
// cycle at a time and queues the hand-derived control word for that cycle; a
// monitor pops and compares on the falling edge.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BR     = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_ECALL  = 7'b1110011;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                         IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_sel;
    logic       is_halted;
    logic       illegal_inst;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       bcond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;
  logic       ir_write, pc_write, i_or_d, mem_read, mem_write, reg_write;
  logic       is_halted, illegal_inst;
  logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_sel;

  vec_t  act;
  vec_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  assign act = {ir_write, pc_write, pc_src, i_or_d, mem_read, mem_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel, is_halted, illegal_inst};

  multi_cycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .bcond        (bcond),
    .mem_ready    (mem_ready),
    .halt_req     (halt_req),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .is_halted    (is_halted),
    .illegal_inst (illegal_inst)
  );

  always #5 clk = ~clk;

  // Expected control words per state (encodings: pc_src PC4/ALUOUT/ALU = 0/1/2,
  // wb_sel ALUOUT/MDR/PC4 = 0/1/2, A PC/RS1/ZERO = 0/1/2, B RS2/IMM = 0/1,
  // alu_op ADD/FUNCT/BRANCH = 0/1/2).
  function automatic vec_t e_if(input logic rdy);
    vec_t v = '0; v.mem_read = 1'b1; v.ir_write = rdy; return v;
  endfunction
  function automatic vec_t e_id(input logic [2:0] imm);
    vec_t v = '0; v.alu_src_b = 2'd1; v.imm_sel = imm; return v;
  endfunction
  function automatic vec_t e_ex(input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] op, input logic [2:0] imm);
    vec_t v = '0; v.alu_src_a = a; v.alu_src_b = b; v.alu_op = op; v.imm_sel = imm;
    return v;
  endfunction
  function automatic vec_t e_wb(input logic [1:0] sel, input logic [2:0] imm);
    vec_t v = '0; v.reg_write = 1'b1; v.wb_sel = sel; v.pc_write = 1'b1;
    v.imm_sel = imm; return v;
  endfunction
  function automatic vec_t e_mem(input logic wr, input logic rdy, input logic [2:0] imm);
    vec_t v = '0; v.i_or_d = 1'b1; v.imm_sel = imm;
    if (wr) begin v.mem_write = 1'b1; v.pc_write = rdy; end
    else    v.mem_read = 1'b1;
    return v;
  endfunction
  function automatic vec_t e_br(input logic taken);
    vec_t v = e_ex(2'd1, 2'd0, 2'd2, IMM_B);
    v.pc_write = 1'b1; v.pc_src = taken ? 2'd1 : 2'd0; return v;
  endfunction
  function automatic vec_t e_imm_only(input logic [2:0] imm);
    vec_t v = '0; v.imm_sel = imm; return v;
  endfunction

  // One clock cycle: drive inputs just after the rising edge, queue the
  // expected control word, advance to the next rising edge.
  task automatic step(input string nm, input logic [6:0] op, input logic rdy,
                      input logic bc, input logic hr, input logic rs, input vec_t e);
    opcode = op; mem_ready = rdy; bcond = bc; halt_req = hr; reset = rs;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  // Monitor: compare the presented control word against the queued one.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", n, act, e, $time);
      end
    end
  end

  initial begin
    vec_t tmp;
    repeat (2) @(posedge clk);
    #1;
    step("reset_idle", OPC_R, 1'b1, 1'b0, 1'b0, 1'b1, '0);

    // ADD, 4 cycles
    step("add_if",   OPC_R, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("add_id",   OPC_R, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_NONE));
    step("add_ex",   OPC_R, 1'b1, 1'b0, 1'b0, 1'b0, e_ex(2'd1, 2'd0, 2'd1, IMM_NONE));
    step("add_wb",   OPC_R, 1'b1, 1'b0, 1'b0, 1'b0, e_wb(2'd0, IMM_NONE));

    // LW with a 3-cycle stall in S_MEM_RD; mem_ready low in ID/EX is ignored
    step("lw_if",    OPC_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("lw_id",    OPC_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, e_id(IMM_I));
    step("lw_addr",  OPC_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, e_ex(2'd1, 2'd1, 2'd0, IMM_I));
    for (int i = 0; i < 3; i++)
      step("lw_stall", OPC_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0, IMM_I));
    step("lw_rdy",   OPC_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b1, IMM_I));
    step("lw_wb",    OPC_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, e_wb(2'd1, IMM_I));

    // Fetch stall once, then BEQ taken / not taken
    step("beq_if_stall", OPC_BR, 1'b0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
    step("beq_if",   OPC_BR, 1'b1, 1'b1, 1'b0, 1'b0, e_if(1'b1));
    step("beq_id",   OPC_BR, 1'b1, 1'b1, 1'b0, 1'b0, e_id(IMM_B));
    step("beq_take", OPC_BR, 1'b1, 1'b1, 1'b0, 1'b0, e_br(1'b1));
    step("beq_if2",  OPC_BR, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("beq_id2",  OPC_BR, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_B));
    step("beq_fall", OPC_BR, 1'b1, 1'b0, 1'b0, 1'b0, e_br(1'b0));

    // SW, 4 cycles
    step("sw_if",    OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("sw_id",    OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_S));
    step("sw_addr",  OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_ex(2'd1, 2'd1, 2'd0, IMM_S));
    step("sw_mem",   OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b1, IMM_S));

    // JAL, 3 cycles
    step("jal_if",   OPC_JAL, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("jal_id",   OPC_JAL, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_J));
    tmp = e_wb(2'd2, IMM_J); tmp.pc_src = 2'd1;
    step("jal_ex",   OPC_JAL, 1'b1, 1'b0, 1'b0, 1'b0, tmp);

    // JALR, 3 cycles
    step("jalr_if",  OPC_JALR, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("jalr_id",  OPC_JALR, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_I));
    tmp = e_wb(2'd2, IMM_I); tmp.pc_src = 2'd2; tmp.alu_src_a = 2'd1; tmp.alu_src_b = 2'd1;
    step("jalr_ex",  OPC_JALR, 1'b1, 1'b0, 1'b0, 1'b0, tmp);

    // LUI, 4 cycles
    step("lui_if",   OPC_LUI, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("lui_id",   OPC_LUI, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_U));
    step("lui_ex",   OPC_LUI, 1'b1, 1'b0, 1'b0, 1'b0, e_ex(2'd2, 2'd1, 2'd0, IMM_U));
    step("lui_wb",   OPC_LUI, 1'b1, 1'b0, 1'b0, 1'b0, e_wb(2'd0, IMM_U));

    // AUIPC, 3 cycles
    step("auipc_if", OPC_AUIPC, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("auipc_id", OPC_AUIPC, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_U));
    step("auipc_wb", OPC_AUIPC, 1'b1, 1'b0, 1'b0, 1'b0, e_wb(2'd0, IMM_U));

    // ADDI, 4 cycles
    step("addi_if",  OPC_I, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("addi_id",  OPC_I, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_I));
    step("addi_ex",  OPC_I, 1'b1, 1'b0, 1'b0, 1'b0, e_ex(2'd1, 2'd1, 2'd1, IMM_I));
    step("addi_wb",  OPC_I, 1'b1, 1'b0, 1'b0, 1'b0, e_wb(2'd0, IMM_I));

    // ECALL without halt, back to fetch
    step("ecall0_if", OPC_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("ecall0_id", OPC_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_I));
    tmp = e_imm_only(IMM_I); tmp.pc_write = 1'b1;
    step("ecall0_ex", OPC_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, tmp);

    // SW stalled, reset mid-stall drops the write at once
    step("sws_if",    OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("sws_id",    OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_S));
    step("sws_addr",  OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, e_ex(2'd1, 2'd1, 2'd0, IMM_S));
    step("sws_stall", OPC_STORE, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, IMM_S));
    step("sws_stall", OPC_STORE, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, IMM_S));
    step("sws_reset", OPC_STORE, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step("sws_refetch", OPC_BAD, 1'b0, 1'b0, 1'b0, 1'b0, e_if(1'b0));

    // Illegal opcode, terminal until reset
    step("ill_if",   OPC_BAD, 1'b1, 1'b0, 1'b0, 1'b0, e_if(1'b1));
    step("ill_id",   OPC_BAD, 1'b1, 1'b0, 1'b0, 1'b0, e_id(IMM_NONE));
    tmp = '0; tmp.illegal_inst = 1'b1;
    for (int i = 0; i < 3; i++)
      step("ill_hold", OPC_BAD, 1'b1, 1'b1, 1'b1, 1'b0, tmp);
    step("ill_reset", OPC_BAD, 1'b1, 1'b0, 1'b0, 1'b1, '0);

    // ECALL with halt, terminal with no further fetch
    step("halt_if",  OPC_ECALL, 1'b1, 1'b0, 1'b1, 1'b0, e_if(1'b1));
    step("halt_id",  OPC_ECALL, 1'b1, 1'b0, 1'b1, 1'b0, e_id(IMM_I));
    step("halt_ec",  OPC_ECALL, 1'b1, 1'b0, 1'b1, 1'b0, e_imm_only(IMM_I));
    tmp = e_imm_only(IMM_I); tmp.is_halted = 1'b1;
    for (int i = 0; i < 3; i++)
      step("halt_hold", OPC_ECALL, 1'b1, 1'b0, 1'b0, 1'b0, tmp);
    step("halt_reset", OPC_ECALL, 1'b1, 1'b0, 1'b0, 1'b1, '0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
